// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI receive frame controller: FSM encoding, frame-format codes
// and the frame-width mask also used by the shifter.
package spi_rx_pkg;

    localparam int TNUM_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_CRC  = 2'b10,
        ST_DONE = 2'b11
    } rx_state_e;

    localparam logic [1:0] DF_8  = 2'b00;
    localparam logic [1:0] DF_16 = 2'b01;
    localparam logic [1:0] DF_32 = 2'b10;

    // Both 1x codes select a 32-bit frame.
    function automatic logic [31:0] df_mask(input logic [1:0] df);
        logic [31:0] m;
        case (df)
            DF_8:           m = 32'h0000_00FF;
            DF_16:          m = 32'h0000_FFFF;
            DF_32, 2'b11:   m = 32'hFFFF_FFFF;
            default:        m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/spi_rx_frame_ctrl_if.sv
// Bus/shifter-side signal bundle for spi_rx_frame_ctrl. The DMA handshake pair exists only when
// SPI_RX_DMA_EN is defined.
interface spi_rx_frame_ctrl_if #(
    parameter int LVL_W = 3
);
    logic             rx_en;
    logic [1:0]       df;
    logic [12:0]      spi_tnum;
    logic             crc_en;
    logic             rx_busy;
    logic [31:0]      spi_rx_data;
    logic [31:0]      rx_crc_data_out;
    logic             rd_en;
    logic             fifo_flush;
    logic             clr_ovr;
    logic             clr_crcerr;
    logic [31:0]      rx_rdata;
    logic             rxne;
    logic             rx_full;
    logic [LVL_W-1:0] rx_lvl;
    logic             ovr;
    logic             crc_err;
    logic             xfer_done;
    logic             ctrl_busy;
`ifdef SPI_RX_DMA_EN
    logic             dma_req;
    logic             dma_ack;
`endif

    modport master (
`ifdef SPI_RX_DMA_EN
        output dma_ack,
        input  dma_req,
`endif
        output rx_en, df, spi_tnum, crc_en, rx_busy, spi_rx_data, rx_crc_data_out,
        output rd_en, fifo_flush, clr_ovr, clr_crcerr,
        input  rx_rdata, rxne, rx_full, rx_lvl, ovr, crc_err, xfer_done, ctrl_busy
    );

    modport slave (
`ifdef SPI_RX_DMA_EN
        input  dma_ack,
        output dma_req,
`endif
        input  rx_en, df, spi_tnum, crc_en, rx_busy, spi_rx_data, rx_crc_data_out,
        input  rd_en, fifo_flush, clr_ovr, clr_crcerr,
        output rx_rdata, rxne, rx_full, rx_lvl, ovr, crc_err, xfer_done, ctrl_busy
    );

endinterface

// File: rtl/spi_rx_fifo.sv
// Synchronous receive FIFO with push, pop, flush and occupancy. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; flush overrides both.
module spi_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_level == LW'(0));
    assign o_full  = (r_level == LW'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_level = r_level;
    assign o_rdata = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_level  <= LW'(0);
        end else if (i_flush) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_level  <= LW'(0);
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/spi_rx_frame_ctrl.sv
// SPI receive frame controller: frame detection, transfer FSM, CRC-frame check and status flags.
// Optional DMA request/ack handshake is built when SPI_RX_DMA_EN is defined.
module spi_rx_frame_ctrl
    import spi_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DMA_THRESH = 1
) (
    input  logic               clk_rx,
    input  logic               spi_rx_rstn,
    spi_rx_frame_ctrl_if.slave bus
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    if (DMA_THRESH < 1 || DMA_THRESH > FIFO_DEPTH) begin : g_bad_thresh
        $error("DMA_THRESH must lie in 1..FIFO_DEPTH");
    end

    rx_state_e         r_state;
    rx_state_e         w_next;
    logic              r_rx_busy_d;
    logic [TNUM_W-1:0] r_frm_cnt;
    logic [31:0]       r_crc_snap;
    logic              r_ovr;
    logic              r_crc_err;

    logic              w_frm_evt;
    logic              w_tnum_zero;
    logic              w_last;
    logic [TNUM_W-1:0] w_cnt_inc;
    logic              w_push;
    logic              w_pop;
    logic              w_crc_bad;
    logic              w_ovr_set;
    logic              w_xfer_done;
    logic              w_ctrl_busy;
    logic              w_full;
    logic              w_empty;
    logic [31:0]       w_rdata;
    logic [LW-1:0]     w_level;

    assign w_frm_evt   = r_rx_busy_d & ~bus.rx_busy;
    assign w_cnt_inc   = r_frm_cnt + 13'd1;
    assign w_tnum_zero = (bus.spi_tnum == 13'd0);
    assign w_last      = w_tnum_zero | (w_frm_evt & (w_cnt_inc == bus.spi_tnum));
    assign w_push      = (r_state == ST_DATA) & bus.rx_en & ~w_tnum_zero & w_frm_evt;
    assign w_crc_bad   = (r_state == ST_CRC) & bus.rx_en & w_frm_evt &
                         (((bus.spi_rx_data ^ r_crc_snap) & df_mask(bus.df)) != 32'd0);
    // A dropped word only counts as overrun when no pop frees a slot and no flush discards it.
    assign w_ovr_set   = w_push & w_full & ~w_pop & ~bus.fifo_flush;

`ifdef SPI_RX_DMA_EN
    assign w_pop       = bus.rd_en | bus.dma_ack;
    assign bus.dma_req = (w_level >= LW'(DMA_THRESH)) & ~bus.fifo_flush;
`else
    assign w_pop       = bus.rd_en;
`endif

    // FSM state register.
    always_ff @(posedge clk_rx or negedge spi_rx_rstn) begin
        if (!spi_rx_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; dropping rx_en aborts from any state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.rx_en) w_next = ST_DATA;
                else           w_next = ST_IDLE;
            end
            ST_DATA: begin
                if (!bus.rx_en) w_next = ST_IDLE;
                else if (w_last) w_next = bus.crc_en ? ST_CRC : ST_DONE;
                else             w_next = ST_DATA;
            end
            ST_CRC: begin
                if (!bus.rx_en)    w_next = ST_IDLE;
                else if (w_frm_evt) w_next = ST_DONE;
                else                w_next = ST_CRC;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        w_xfer_done = 1'b0;
        w_ctrl_busy = 1'b1;
        case (r_state)
            ST_IDLE: w_ctrl_busy = 1'b0;
            ST_DONE: w_xfer_done = 1'b1;
            default: w_ctrl_busy = 1'b1;
        endcase
    end

    // Frame counter, CRC snapshot, busy delay and sticky flags (set beats clear).
    always_ff @(posedge clk_rx or negedge spi_rx_rstn) begin
        if (!spi_rx_rstn) begin
            r_rx_busy_d <= 1'b0;
            r_frm_cnt   <= 13'd0;
            r_crc_snap  <= 32'd0;
            r_ovr       <= 1'b0;
            r_crc_err   <= 1'b0;
        end else begin
            r_rx_busy_d <= bus.rx_busy;
            if ((r_state == ST_IDLE) && bus.rx_en) begin
                r_frm_cnt <= 13'd0;
            end else if (w_push) begin
                r_frm_cnt <= w_cnt_inc;
            end
            if ((r_state == ST_DATA) && (w_next == ST_CRC)) begin
                r_crc_snap <= bus.rx_crc_data_out;
            end
            if (w_ovr_set)        r_ovr <= 1'b1;
            else if (bus.clr_ovr) r_ovr <= 1'b0;
            if (w_crc_bad)           r_crc_err <= 1'b1;
            else if (bus.clr_crcerr) r_crc_err <= 1'b0;
        end
    end

    spi_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_clk   (clk_rx),
        .i_rst_n (spi_rx_rstn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.fifo_flush),
        .i_wdata (bus.spi_rx_data),
        .o_rdata (w_rdata),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.rx_rdata  = w_rdata;
    assign bus.rxne      = ~w_empty;
    assign bus.rx_full   = w_full;
    assign bus.rx_lvl    = w_level;
    assign bus.ovr       = r_ovr;
    assign bus.crc_err   = r_crc_err;
    assign bus.xfer_done = w_xfer_done;
    assign bus.ctrl_busy = w_ctrl_busy;

endmodule

// File: tb/tb_spi_rx_frame_ctrl.sv
// Directed, table-driven bench for spi_rx_frame_ctrl (FIFO_DEPTH=4, DMA_THRESH=2).
// The DMA sequence is compiled in only with SPI_RX_DMA_EN.
module tb_spi_rx_frame_ctrl;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    spi_rx_frame_ctrl_if #(.LVL_W(3)) bus ();

    spi_rx_frame_ctrl #(
        .FIFO_DEPTH (4),
        .DMA_THRESH (2)
    ) dut (
        .clk_rx      (clk),
        .spi_rx_rstn (rstn),
        .bus         (bus)
    );

    always @(posedge clk) begin
        if (bus.xfer_done) done_cnt <= done_cnt + 1;
    end

    typedef struct packed {
        logic [1:0]       df;
        logic [12:0]      tnum;
        logic             crc_en;
        logic [31:0]      crc_run;
        logic [2:0]       nfrm;
        logic [0:5][31:0] frm;
        logic [2:0]       lvl;
        logic             full;
        logic             ovr;
        logic             cerr;
        logic [2:0]       npop;
        logic [0:3][31:0] pops;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input logic [1:0] df, input logic [12:0] tnum, input logic crc_en,
                                input logic [31:0] crc_run, input logic [2:0] nfrm,
                                input logic [0:5][31:0] frm, input logic [2:0] lvl, input logic full,
                                input logic ovr, input logic cerr, input logic [2:0] npop,
                                input logic [0:3][31:0] pops);
        vec_t v;
        v.df = df; v.tnum = tnum; v.crc_en = crc_en; v.crc_run = crc_run; v.nfrm = nfrm;
        v.frm = frm; v.lvl = lvl; v.full = full; v.ovr = ovr; v.cerr = cerr;
        v.npop = npop; v.pops = pops;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [31:0] w);
        @(negedge clk);
        bus.rx_busy = 1'b1;
        bus.spi_rx_data = w;
        repeat (2) @(negedge clk);
        bus.rx_busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int target, input string nm);
        int n = 0;
        while (done_cnt < target && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL %s: xfer_done timeout, got count %0d expected %0d", nm, done_cnt, target);
        end
    endtask

    task automatic pop_chk(input string nm, input logic [31:0] exp);
        chk(nm, bus.rx_rdata, exp);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic clr_all();
        bus.fifo_flush = 1'b1;
        bus.clr_ovr = 1'b1;
        bus.clr_crcerr = 1'b1;
        @(negedge clk);
        bus.fifo_flush = 1'b0;
        bus.clr_ovr = 1'b0;
        bus.clr_crcerr = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] df, input logic [12:0] tnum, input logic crc_en);
        bus.df = df;
        bus.spi_tnum = tnum;
        bus.crc_en = crc_en;
    endtask

    initial begin
        int start;
        rstn = 1'b0;
        bus.rx_en = 1'b0; bus.df = 2'b00; bus.spi_tnum = 13'd0; bus.crc_en = 1'b0;
        bus.rx_busy = 1'b0; bus.spi_rx_data = 32'd0; bus.rx_crc_data_out = 32'd0;
        bus.rd_en = 1'b0; bus.fifo_flush = 1'b0; bus.clr_ovr = 1'b0; bus.clr_crcerr = 1'b0;
`ifdef SPI_RX_DMA_EN
        bus.dma_ack = 1'b0;
`endif
        //            df     tnum   crc   crc_run        n  frames                                                      lvl  full ovr  cerr np  pops
        vecs[0] = mk(2'b00, 13'd3, 1'b0, 32'h0,        3'd3, {32'hA5, 32'h3C, 32'hFF, 96'h0},                      3'd3, 1'b0, 1'b0, 1'b0, 3'd3, {32'hA5, 32'h3C, 32'hFF, 32'h0});
        vecs[1] = mk(2'b00, 13'd5, 1'b0, 32'h0,        3'd5, {32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h0},      3'd4, 1'b1, 1'b1, 1'b0, 3'd4, {32'h11, 32'h22, 32'h33, 32'h44});
        vecs[2] = mk(2'b01, 13'd2, 1'b1, 32'h1D0F,     3'd3, {32'h1234, 32'hABCD, 32'h1D0F, 96'h0},                3'd2, 1'b0, 1'b0, 1'b0, 3'd2, {32'h1234, 32'hABCD, 64'h0});
        vecs[3] = mk(2'b01, 13'd2, 1'b1, 32'h1D0F,     3'd3, {32'h1234, 32'hABCD, 32'h1D0E, 96'h0},                3'd2, 1'b0, 1'b0, 1'b1, 3'd2, {32'h1234, 32'hABCD, 64'h0});
        vecs[4] = mk(2'b00, 13'd1, 1'b1, 32'h0000_00AB, 3'd2, {32'h77, 32'hFFFF_FFAB, 128'h0},                     3'd1, 1'b0, 1'b0, 1'b0, 3'd1, {32'h77, 96'h0});
        vecs[5] = mk(2'b10, 13'd1, 1'b1, 32'hDEAD_BEEF, 3'd2, {32'h5AA5_0001, 32'hDEAD_BEEE, 128'h0},             3'd1, 1'b0, 1'b0, 1'b1, 3'd1, {32'h5AA5_0001, 96'h0});
        vecs[6] = mk(2'b01, 13'd0, 1'b0, 32'h0,        3'd0, {192'h0},                                              3'd0, 1'b0, 1'b0, 1'b0, 3'd0, {128'h0});
        vecs[7] = mk(2'b11, 13'd1, 1'b1, 32'h0001_0000, 3'd2, {32'h42, 32'h0, 128'h0},                              3'd1, 1'b0, 1'b0, 1'b1, 3'd1, {32'h42, 96'h0});

        repeat (3) @(negedge clk);
        chk("rst_rxne", 32'(bus.rxne), 32'd0);
        chk("rst_lvl", 32'(bus.rx_lvl), 32'd0);
        chk("rst_rdata", bus.rx_rdata, 32'd0);
        chk("rst_full", 32'(bus.rx_full), 32'd0);
        chk("rst_ovr", 32'(bus.ovr), 32'd0);
        chk("rst_crcerr", 32'(bus.crc_err), 32'd0);
        chk("rst_done", 32'(bus.xfer_done), 32'd0);
        chk("rst_busy", 32'(bus.ctrl_busy), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            clr_all();
            set_cfg(vecs[i].df, vecs[i].tnum, vecs[i].crc_en);
            bus.rx_crc_data_out = vecs[i].crc_run;
            start = done_cnt;
            bus.rx_en = 1'b1;
            for (int f = 0; f < int'(vecs[i].nfrm); f++) send_frame(vecs[i].frm[f]);
            wait_done(start + 1, $sformatf("v%0d_done", i));
            bus.rx_en = 1'b0;
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_ndone", i), 32'(done_cnt - start), 32'd1);
            chk($sformatf("v%0d_lvl", i), 32'(bus.rx_lvl), 32'(vecs[i].lvl));
            chk($sformatf("v%0d_full", i), 32'(bus.rx_full), 32'(vecs[i].full));
            chk($sformatf("v%0d_ovr", i), 32'(bus.ovr), 32'(vecs[i].ovr));
            chk($sformatf("v%0d_crcerr", i), 32'(bus.crc_err), 32'(vecs[i].cerr));
            for (int p = 0; p < int'(vecs[i].npop); p++) pop_chk($sformatf("v%0d_pop%0d", i, p), vecs[i].pops[p]);
            chk($sformatf("v%0d_empty_rxne", i), 32'(bus.rxne), 32'd0);
            chk($sformatf("v%0d_empty_rdata", i), bus.rx_rdata, 32'd0);
        end

        // Full FIFO: push and pop in the same cycle.
        clr_all();
        set_cfg(2'b00, 13'd6, 1'b0);
        start = done_cnt;
        bus.rx_en = 1'b1;
        for (int f = 1; f <= 4; f++) send_frame(32'(f));
        chk("pp_full_before", 32'(bus.rx_full), 32'd1);
        @(negedge clk);
        bus.rx_busy = 1'b1; bus.spi_rx_data = 32'd5;
        repeat (2) @(negedge clk);
        bus.rx_busy = 1'b0; bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        chk("pp_lvl", 32'(bus.rx_lvl), 32'd4);
        chk("pp_ovr", 32'(bus.ovr), 32'd0);
        chk("pp_head", bus.rx_rdata, 32'd2);
        bus.rx_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("pp_abort_nodone", 32'(done_cnt - start), 32'd0);
        chk("pp_abort_idle", 32'(bus.ctrl_busy), 32'd0);
        for (int p = 2; p <= 5; p++) pop_chk($sformatf("pp_pop%0d", p), 32'(p));

        // rx_en drops after frame 2 of 4, then a fresh transfer counts from zero.
        clr_all();
        set_cfg(2'b00, 13'd4, 1'b0);
        start = done_cnt;
        bus.rx_en = 1'b1;
        send_frame(32'hA1);
        send_frame(32'hA2);
        bus.rx_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("ab_nodone", 32'(done_cnt - start), 32'd0);
        chk("ab_idle", 32'(bus.ctrl_busy), 32'd0);
        chk("ab_lvl_kept", 32'(bus.rx_lvl), 32'd2);
        clr_all();
        bus.rx_en = 1'b1;
        for (int f = 0; f < 3; f++) send_frame(32'hB0 + 32'(f));
        chk("ab_restart_nodone", 32'(done_cnt - start), 32'd0);
        chk("ab_restart_busy", 32'(bus.ctrl_busy), 32'd1);
        send_frame(32'hB3);
        wait_done(start + 1, "ab_restart_done");
        bus.rx_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("ab_restart_ndone", 32'(done_cnt - start), 32'd1);
        chk("ab_restart_lvl", 32'(bus.rx_lvl), 32'd4);
        chk("ab_restart_ovr", 32'(bus.ovr), 32'd0);
        chk("ab_restart_head", bus.rx_rdata, 32'hB0);

        // Overrun set wins over same-cycle clear; pop on empty is ignored.
        clr_all();
        set_cfg(2'b00, 13'd5, 1'b0);
        start = done_cnt;
        bus.rx_en = 1'b1;
        for (int f = 0; f < 4; f++) send_frame(32'hC0 + 32'(f));
        @(negedge clk);
        bus.rx_busy = 1'b1; bus.spi_rx_data = 32'hC4;
        repeat (2) @(negedge clk);
        bus.rx_busy = 1'b0; bus.clr_ovr = 1'b1;
        @(negedge clk);
        bus.clr_ovr = 1'b0;
        chk("fl_set_beats_clr", 32'(bus.ovr), 32'd1);
        wait_done(start + 1, "fl_done");
        bus.rx_en = 1'b0;
        bus.clr_ovr = 1'b1;
        @(negedge clk);
        bus.clr_ovr = 1'b0;
        chk("fl_clr", 32'(bus.ovr), 32'd0);
        chk("fl_head", bus.rx_rdata, 32'hC0);
        clr_all();
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        chk("empty_pop_lvl", 32'(bus.rx_lvl), 32'd0);
        chk("empty_pop_rdata", bus.rx_rdata, 32'd0);

        // Reset in the middle of a transfer.
        set_cfg(2'b00, 13'd4, 1'b0);
        bus.rx_en = 1'b1;
        send_frame(32'hD1);
        send_frame(32'hD2);
        chk("mr_lvl_pre", 32'(bus.rx_lvl), 32'd2);
        rstn = 1'b0;
        #1;
        chk("mr_lvl", 32'(bus.rx_lvl), 32'd0);
        chk("mr_rxne", 32'(bus.rxne), 32'd0);
        chk("mr_busy", 32'(bus.ctrl_busy), 32'd0);
        chk("mr_rdata", bus.rx_rdata, 32'd0);
        bus.rx_en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

`ifdef SPI_RX_DMA_EN
        clr_all();
        set_cfg(2'b00, 13'd4, 1'b0);
        bus.rx_en = 1'b1;
        send_frame(32'hE1);
        chk("dma_lvl1", 32'(bus.dma_req), 32'd0);
        send_frame(32'hE2);
        chk("dma_lvl2", 32'(bus.dma_req), 32'd1);
        bus.rx_en = 1'b0;
        bus.dma_ack = 1'b1;
        @(negedge clk);
        bus.dma_ack = 1'b0;
        chk("dma_ack1_lvl", 32'(bus.rx_lvl), 32'd1);
        chk("dma_ack1_head", bus.rx_rdata, 32'hE2);
        bus.dma_ack = 1'b1;
        @(negedge clk);
        bus.dma_ack = 1'b0;
        chk("dma_ack2_req", 32'(bus.dma_req), 32'd0);
        chk("dma_ack2_lvl", 32'(bus.rx_lvl), 32'd0);
        bus.rx_en = 1'b1;
        send_frame(32'hE3);
        send_frame(32'hE4);
        bus.rx_en = 1'b0;
        bus.fifo_flush = 1'b1;
        #1;
        chk("dma_flush_gate", 32'(bus.dma_req), 32'd0);
        bus.fifo_flush = 1'b0;
        bus.rd_en = 1'b1; bus.dma_ack = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0; bus.dma_ack = 1'b0;
        chk("dma_dual_pop_lvl", 32'(bus.rx_lvl), 32'd1);
        chk("dma_dual_pop_head", bus.rx_rdata, 32'hE4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
